licz_mod: RTL
=============

LICZ_MOD -- requirements
Module: licz_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 256: count modulus; legal range 2..2^WIDTH; counter sequence is 0..MODULUS-1.
REQ-003 Parameter SAT, default 0: 0 = wrap at the terminal value, 1 = saturate (hold) at the terminal value.
REQ-004 Port in, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset, sampled on the rising edge of in.
REQ-006 Port en, input, 1: count enable.
REQ-007 Port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-008 Port load, input, 1: synchronous parallel load request.
REQ-009 Port d, input, WIDTH: parallel load value.
REQ-010 Port out, output, WIDTH: registered count value.
REQ-011 Port tc, output, 1: terminal count, combinational, intended for cascading stages.
REQ-012 Port ovf, output, 1: registered sticky wrap/saturation flag.

Function
REQ-013 Per-edge priority: reset low > load high > en high (count) > hold.
REQ-014 On load: out <= d if d < MODULUS, else out <= MODULUS-1; ignores en and up.
REQ-015 On count, up=1 and out < MODULUS-1: out <= out+1.
REQ-016 On count, up=0 and out > 0: out <= out-1.
REQ-017 On count, up=1 and out == MODULUS-1: out <= 0 if SAT=0, else out holds.
REQ-018 On count, up=0 and out == 0: out <= MODULUS-1 if SAT=0, else out holds.
REQ-019 Arithmetic carries no bits beyond WIDTH; out never holds a value >= MODULUS.
REQ-020 tc = en & reset & ((up & out==MODULUS-1) | (~up & out==0)); zero latency, so a higher stage's en tied to a lower stage's tc advances on the same edge as the lower stage wraps.
REQ-021 ovf sets on any edge where the count branch runs with tc=1 (wrap or saturation event), in both SAT modes.
REQ-022 ovf stays set until the next reset or load edge; a load edge clears ovf.
REQ-023 en low with load low: out and ovf hold; up changes while en is low have no effect except on tc.
REQ-024 Direction reversal takes effect on the next enabled edge; no dead cycle.
REQ-025 For MODULUS == 2^WIDTH, the wrap compare is bitwise; no extra state is required.

Reset
REQ-026 reset low at a rising edge: out <= 0 and ovf <= 0, overriding load and en in that cycle.
REQ-027 While reset is low, tc is 0.
REQ-028 A reset edge mid-count takes effect on that edge; counting resumes from 0 on the first edge with reset high and en high.
REQ-029 The block has no asynchronous path; before the first reset edge, out and ovf are undefined.

Verification
REQ-030 Defaults; reset low 1 edge, then en=1, up=1 for 300 edges -> out 0,1,...,255,0,...,43; tc high while out=255; ovf set on the 256th enabled edge.
REQ-031 MODULUS=10, SAT=0, up=0 from reset -> out 9,8,...,0,9; tc high at out=0; load d=15 -> out=9 and ovf=0.
REQ-032 MODULUS=10, SAT=1; load d=7, up=1, en=1 for 5 edges -> out 8,9,9,9,9; ovf=1 from the 3rd edge on; then up=0 -> out 8.
REQ-033 Load and en both high with d=0x55 at out=0x10 -> out=0x55; load wins.
REQ-034 Reset low while load=1, en=1, out=0x80 -> out=0, ovf=0, tc=0 that cycle.
REQ-035 Two WIDTH=4, MODULUS=16 instances cascaded (upper en = lower tc), 256 enabled edges -> combined value counts 0..255 then returns to 0; upper ovf set on the last edge.

Source files
------------

// File: rtl/licz_mod.sv
// licz_mod: modulo-N up/down counter with parallel load, optional saturation,
// a combinational terminal-count output for cascading, and a sticky overflow flag.
//
// Parameters:
//   WIDTH   - counter width in bits (1..32)
//   MODULUS - count modulus (2..2^WIDTH); sequence is 0..MODULUS-1
//   SAT     - 0: wrap at the terminal value, 1: hold at the terminal value
// Ports:
//   in    - clock, all state changes on its rising edge
//   reset - synchronous active-low reset
//   en    - count enable
//   up    - direction, 1 = increment, 0 = decrement
//   load  - synchronous parallel load (clamped to MODULUS-1)
//   d     - parallel load value
//   out   - registered count
//   tc    - terminal count, combinational; drive the next stage's en with it
//   ovf   - sticky wrap/saturation flag, cleared by reset or load
module licz_mod #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 256,
  parameter bit              SAT     = 1'b0
) (
  input  logic             in,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  // Terminal value; for MODULUS == 2^WIDTH this is all ones, so the wrap
  // compare and the +1/-1 arithmetic need no extra bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot;

  assign at_top = (cnt_q == MaxVal);
  assign at_bot = (cnt_q == '0);

  // Zero-latency so a cascaded stage advances on the same edge as this one wraps.
  assign tc = en & reset & ((up & at_top) | (~up & at_bot));

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (load) begin
      // d >= MODULUS is equivalent to d > MaxVal, which avoids a WIDTH+1 compare.
      cnt_d = (d > MaxVal) ? MaxVal : d;
      ovf_d = 1'b0;
    end else if (en) begin
      if (tc) begin
        ovf_d = 1'b1;
        if (!SAT) begin
          cnt_d = up ? '0 : MaxVal;
        end
      end else begin
        cnt_d = up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge in) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = cnt_q;
  assign ovf = ovf_q;

endmodule
